uart_tx_param: RTL and testbench

//  Parametrised UART transmitter: serialises DATA_W-bit words with start bit, optional parity and 1/2 stop bits.

---
 rtl/uart_tx_param_pkg.sv | 29 ++
 rtl/uart_tx_param_if.sv | 13 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx_param.sv | 156 +++++++++++++++
 tb/tb_uart_tx_param.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_param_pkg.sv
// Shared UART definitions: parity mode codes, transmitter state encoding and
// the parity-bit rule, common to the TX and future RX sides.
package uart_tx_param_pkg;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;
  localparam int PAR_MARK  = 3;
  localparam int PAR_SPACE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // data_xor is the XOR-reduction of the latched data word
  function automatic logic parity_bit(int mode, logic data_xor);
    case (mode)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word-side handshake plus serial line and status of the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              txd;
  logic              busy;

  modport master (output tx_valid, tx_data, input tx_ready, txd, busy);
  modport slave  (input tx_valid, tx_data, output tx_ready, txd, busy);
endinterface

// File: rtl/uart_baud_cnt.sv
// Baud-interval counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of a bit
// (bit_end) and the cycle before it (pre_end).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign pre_end = (cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits, optional parity,
// 1 or 2 stop bits; valid/ready word input with gap-free back-to-back frames.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input logic           clk,
  input logic           nrst,
  uart_tx_param_if.slave tx
);

  if (PARITY < PAR_NONE || PARITY > PAR_SPACE) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0..4");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              par;
  logic              txd_q;
  logic              ready_q;
  logic              busy_q;

  logic              bit_end;
  logic              pre_end;
  logic              accept;
  logic              last_stop;
  logic              front;
  logic [DATA_W-1:0] shifted;

  // Counter is held at zero in IDLE; every other state entry happens on bit_end,
  // where the counter wraps to zero by itself.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (state == ST_IDLE),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  assign accept    = tx.tx_valid && ready_q;
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign front     = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
  assign shifted   = (LSB_FIRST != 0) ? {1'b0, shreg[DATA_W-1:1]}
                                      : {shreg[DATA_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg  <= tx.tx_data;
            par    <= parity_bit(PARITY, ^tx.tx_data);
            state  <= ST_START;
            txd_q  <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            txd_q   <= front;
            shreg   <= shifted;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                txd_q <= par;
              end else begin
                state    <= ST_STOP;
                txd_q    <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd_q   <= front;
              shreg   <= shifted;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            txd_q    <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        ST_STOP: begin
          // ready is registered, so it is raised one cycle ahead of the last stop cycle
          if (bit_end) begin
            if (!last_stop) begin
              stop_cnt <= 1'b1;
            end else if (accept) begin
              shreg <= tx.tx_data;
              par   <= parity_bit(PARITY, ^tx.tx_data);
              state <= ST_START;
              txd_q <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end else if (pre_end && last_stop) begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx.txd      = txd_q;
  assign tx.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: five parameterisations driven with
// directed and random words, checked per cycle against a frame-level model.
module tb_uart_tx_param;

  localparam int NI = 5;
  localparam int CFG_DW  [NI] = '{8, 5, 8, 9, 7};
  localparam int CFG_CPB [NI] = '{4, 3, 2, 4, 4};
  localparam int CFG_PAR [NI] = '{1, 2, 3, 4, 0};
  localparam int CFG_STOP[NI] = '{1, 1, 1, 1, 2};
  localparam int CFG_LSB [NI] = '{1, 1, 1, 1, 0};

  logic       clk;
  logic       nrst;
  logic       vld[NI];
  logic [8:0] dat[NI];
  logic       ser[NI];
  logic       bsy[NI];
  logic       rdy[NI];

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  uart_tx_param_if #(.DATA_W(8)) bus0 ();
  uart_tx_param_if #(.DATA_W(5)) bus1 ();
  uart_tx_param_if #(.DATA_W(8)) bus2 ();
  uart_tx_param_if #(.DATA_W(9)) bus3 ();
  uart_tx_param_if #(.DATA_W(7)) bus4 ();

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1))
    u0 (.clk(clk), .nrst(nrst), .tx(bus0));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1))
    u1 (.clk(clk), .nrst(nrst), .tx(bus1));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY(3), .STOP_BITS(1), .LSB_FIRST(1))
    u2 (.clk(clk), .nrst(nrst), .tx(bus2));
  uart_tx_param #(.DATA_W(9), .CLKS_PER_BIT(4), .PARITY(4), .STOP_BITS(1), .LSB_FIRST(1))
    u3 (.clk(clk), .nrst(nrst), .tx(bus3));
  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(0))
    u4 (.clk(clk), .nrst(nrst), .tx(bus4));

  assign bus0.tx_valid = vld[0]; assign bus0.tx_data = dat[0][7:0];
  assign bus1.tx_valid = vld[1]; assign bus1.tx_data = dat[1][4:0];
  assign bus2.tx_valid = vld[2]; assign bus2.tx_data = dat[2][7:0];
  assign bus3.tx_valid = vld[3]; assign bus3.tx_data = dat[3][8:0];
  assign bus4.tx_valid = vld[4]; assign bus4.tx_data = dat[4][6:0];
  assign ser[0] = bus0.txd; assign bsy[0] = bus0.busy; assign rdy[0] = bus0.tx_ready;
  assign ser[1] = bus1.txd; assign bsy[1] = bus1.busy; assign rdy[1] = bus1.tx_ready;
  assign ser[2] = bus2.txd; assign bsy[2] = bus2.busy; assign rdy[2] = bus2.tx_ready;
  assign ser[3] = bus3.txd; assign bsy[3] = bus3.busy; assign rdy[3] = bus3.tx_ready;
  assign ser[4] = bus4.txd; assign bsy[4] = bus4.busy; assign rdy[4] = bus4.tx_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame: start 0, data in configured order, parity rule, stop 1s
  function automatic void build_frame(int k, logic [8:0] w);
    int ones;
    int idx;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < CFG_DW[k]; i++) begin
      idx = (CFG_LSB[k] != 0) ? i : CFG_DW[k] - 1 - i;
      exp_q.push_back(w[idx]);
      ones += int'(w[i]);
    end
    case (CFG_PAR[k])
      1: exp_q.push_back((ones % 2) == 1);
      2: exp_q.push_back((ones % 2) == 0);
      3: exp_q.push_back(1'b1);
      4: exp_q.push_back(1'b0);
      default: ;
    endcase
    for (int s = 0; s < CFG_STOP[k]; s++) exp_q.push_back(1'b1);
  endfunction

  // Waits (bounded) for tx_ready at a falling edge, then hands over one word
  task automatic start_word(int k, logic [8:0] w);
    int n;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait u%0d: tx_ready got %b want 1", k, rdy[k]);
    end
    vld[k] = 1'b1;
    dat[k] = w;
    @(negedge clk);
    vld[k] = 1'b0;
    dat[k] = 9'($urandom);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({ser[k], bsy[k], rdy[k]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_state u%0d: txd/busy/ready got %b%b%b want 100", k, ser[k], bsy[k], rdy[k]);
      end
    end
    nrst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({ser[k], bsy[k], rdy[k]} !== 3'b101) begin
        errors++;
        $display("FAIL reset_release u%0d: txd/busy/ready got %b%b%b want 101", k, ser[k], bsy[k], rdy[k]);
      end
    end
  endtask

  task automatic test_even_directed();
    logic [10:0] seq;
    logic [2:0]  e;
    seq = 11'b01010010101;
    start_word(0, 9'h0A5);
    for (int c = 0; c < 44; c++) begin
      e = {seq[10 - c / 4], 1'b1, c == 43};
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== e) begin
        errors++;
        $display("FAIL even_a5 cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[0], bsy[0], rdy[0], e);
      end
      @(negedge clk);
    end
    checks++;
    if ({ser[0], bsy[0], rdy[0]} !== 3'b101) begin
      errors++;
      $display("FAIL even_a5_idle: txd/busy/ready got %b%b%b want 101", ser[0], bsy[0], rdy[0]);
    end
  endtask

  task automatic test_parity_modes();
    logic [2:0] e;
    int         n;
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        build_frame(k, (j == 0) ? 9'h001 : 9'h003);
        n = exp_q.size() * CFG_CPB[k];
        start_word(k, (j == 0) ? 9'h001 : 9'h003);
        for (int c = 0; c < n; c++) begin
          e = {exp_q[c / CFG_CPB[k]], 1'b1, c == n - 1};
          checks++;
          if ({ser[k], bsy[k], rdy[k]} !== e) begin
            errors++;
            $display("FAIL parity u%0d word %0d cycle %0d: got %b%b%b want %b", k, j, c, ser[k], bsy[k], rdy[k], e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int         n;
    build_frame(0, 9'h055);
    n = exp_q.size() * 4;
    start_word(0, 9'h055);
    vld[0] = 1'b1;
    dat[0] = 9'h00F;
    for (int c = 0; c < n; c++) begin
      e = {exp_q[c / 4], 1'b1, c == n - 1};
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== e) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[0], bsy[0], rdy[0], e);
      end
      @(negedge clk);
    end
    vld[0] = 1'b0;
    build_frame(0, 9'h00F);
    for (int c = 0; c < n; c++) begin
      e = {exp_q[c / 4], 1'b1, c == n - 1};
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== e) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[0], bsy[0], rdy[0], e);
      end
      @(negedge clk);
    end
    checks++;
    if ({ser[0], bsy[0], rdy[0]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_idle: txd/busy/ready got %b%b%b want 101", ser[0], bsy[0], rdy[0]);
    end
  endtask

  task automatic test_msb_two_stop();
    logic [9:0] seq;
    logic [2:0] e;
    seq = 10'b0100000111;
    start_word(4, 9'h041);
    for (int c = 0; c < 40; c++) begin
      e = {seq[9 - c / 4], 1'b1, c == 39};
      checks++;
      if ({ser[4], bsy[4], rdy[4]} !== e) begin
        errors++;
        $display("FAIL msb_41 cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[4], bsy[4], rdy[4], e);
      end
      @(negedge clk);
    end
    checks++;
    if ({ser[4], bsy[4], rdy[4]} !== 3'b101) begin
      errors++;
      $display("FAIL msb_41_idle: txd/busy/ready got %b%b%b want 101", ser[4], bsy[4], rdy[4]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w;
    logic [2:0] e;
    int         n;
    start_word(0, 9'h0FF);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({ser[0], bsy[0], rdy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_immediate: txd/busy/ready got %b%b%b want 100", ser[0], bsy[0], rdy[0]);
    end
    @(negedge clk);
    checks++;
    if ({ser[0], bsy[0], rdy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_held: txd/busy/ready got %b%b%b want 100", ser[0], bsy[0], rdy[0]);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ser[0], bsy[0], rdy[0]} !== 3'b101) begin
      errors++;
      $display("FAIL abort_release: txd/busy/ready got %b%b%b want 101", ser[0], bsy[0], rdy[0]);
    end
    w = 9'($urandom);
    build_frame(0, w);
    n = exp_q.size() * 4;
    start_word(0, w);
    for (int c = 0; c < n; c++) begin
      e = {exp_q[c / 4], 1'b1, c == n - 1};
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== e) begin
        errors++;
        $display("FAIL after_abort cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[0], bsy[0], rdy[0], e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_valid_while_busy();
    logic [2:0] e;
    int         n;
    build_frame(0, 9'h0C3);
    n = exp_q.size() * 4;
    start_word(0, 9'h0C3);
    for (int c = 0; c < n; c++) begin
      if (c == 5 || c == 30) begin
        vld[0] = 1'b1;
        dat[0] = 9'($urandom);
      end
      if (c == 9 || c == n - 2) vld[0] = 1'b0;
      e = {exp_q[c / 4], 1'b1, c == n - 1};
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== e) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: txd/busy/ready got %b%b%b want %b", c, ser[0], bsy[0], rdy[0], e);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({ser[0], bsy[0], rdy[0]} !== 3'b101) begin
        errors++;
        $display("FAIL busy_ignore_idle %0d: txd/busy/ready got %b%b%b want 101", c, ser[0], bsy[0], rdy[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [8:0] w;
    logic [2:0] e;
    int         n;
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 6; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        w = 9'($urandom);
        build_frame(k, w);
        n = exp_q.size() * CFG_CPB[k];
        start_word(k, w);
        for (int c = 0; c < n; c++) begin
          e = {exp_q[c / CFG_CPB[k]], 1'b1, c == n - 1};
          checks++;
          if ({ser[k], bsy[k], rdy[k]} !== e) begin
            errors++;
            $display("FAIL random u%0d word %h cycle %0d: got %b%b%b want %b", k, w, c, ser[k], bsy[k], rdy[k], e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    nrst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    #1 nrst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_even_directed();
    test_parity_modes();
    test_back_to_back();
    test_msb_two_stop();
    test_reset_mid_frame();
    test_valid_while_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
